// File: rtl/lfsr_pkg.sv
// Shared constants for the parameterised LFSR: step-mode encodings and
// the default 4-bit polynomial and seed.
package lfsr_pkg;

    localparam logic MODE_FIB = 1'b0;
    localparam logic MODE_GAL = 1'b1;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam logic [3:0]  DEFAULT_TAPS  = 4'b1001;
    localparam logic [3:0]  DEFAULT_SEED  = 4'b0001;

endpackage

// File: rtl/lfsr_next.sv
// Combinational single-step successor of an LFSR state, in either
// Fibonacci (shift left, parity in at bit 0) or Galois (shift right, xor taps) form.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS)
) (
    input  logic             mode,
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    logic fb;

    always_comb begin
        fb = ^(cur & TAPS);
        if (mode == MODE_GAL) begin
            nxt = (cur >> 1) ^ (cur[0] ? TAPS : '0);
        end else begin
            nxt = {cur[WIDTH-2:0], fb};
        end
    end

endmodule

// File: rtl/lfsr_param.sv
// Parameterised LFSR with seed load, step counter since the start value,
// a wrap pulse on return to the start value, and rejection of all-zero loads.
module lfsr_param
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             mode,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] steps,
    output logic             wrap,
    output logic             seed_err
);

    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] next_state;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .mode (mode),
        .cur  (out),
        .nxt  (next_state)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out      <= SEED;
            start    <= SEED;
            steps    <= '0;
            wrap     <= 1'b0;
            seed_err <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            seed_err <= 1'b0;
            if (load) begin
                // An all-zero seed would lock the register; fall back to SEED.
                if (seed_in != '0) begin
                    out   <= seed_in;
                    start <= seed_in;
                end else begin
                    out      <= SEED;
                    start    <= SEED;
                    seed_err <= 1'b1;
                end
                steps <= '0;
            end else if (en) begin
                out <= next_state;
                if (next_state == start) begin
                    wrap  <= 1'b1;
                    steps <= '0;
                end else begin
                    steps <= steps + WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_param.sv
// Scoreboard bench for lfsr_param: stimulus pushes expected outputs from an
// arithmetic reference model; a monitor pops and compares after each edge.
module tb_lfsr_param;

    localparam int unsigned W    = 4;
    localparam logic [3:0]  TAPS = 4'b1001;
    localparam logic [3:0]  SEED = 4'b0001;
    localparam int          TAPS_I = 9;
    localparam int          SEED_I = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         load;
    logic [W-1:0] seed_in;
    logic         mode;
    logic [W-1:0] out;
    logic [W-1:0] steps;
    logic         wrap;
    logic         seed_err;

    typedef struct {
        string      name;
        logic [3:0] o;
        logic [3:0] s;
        logic       w;
        logic       e;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    event async_ev;
    event done_ev;

    int m_out, m_start, m_steps;

    always #5 clk = ~clk;

    lfsr_param #(
        .WIDTH (W),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .seed_in  (seed_in),
        .mode     (mode),
        .out      (out),
        .steps    (steps),
        .wrap     (wrap),
        .seed_err (seed_err)
    );

    // Reference step from the polynomial rules using plain integer arithmetic.
    function automatic int model_next(int cur, bit md);
        int ones;
        ones = 0;
        if (!md) begin
            for (int i = 0; i < 4; i++)
                if (((cur / (1 << i)) % 2 == 1) && ((TAPS_I / (1 << i)) % 2 == 1))
                    ones++;
            return ((cur * 2) % 16) + (ones % 2);
        end
        return (cur / 2) ^ ((cur % 2 == 1) ? TAPS_I : 0);
    endfunction

    task automatic push(string nm, int o, int s, bit w, bit e);
        exp_t x;
        x.name = nm;
        x.o    = 4'(o);
        x.s    = 4'(s);
        x.w    = w;
        x.e    = e;
        q.push_back(x);
    endtask

    // Drives one cycle of inputs at the falling edge and queues the model's
    // prediction for the following rising edge.
    task automatic model_cycle(string nm, bit e, bit l, int sd, bit md);
        bit w, err;
        int n;
        @(negedge clk);
        rst = 1'b0; en = e; load = l; seed_in = 4'(sd); mode = md;
        w = 1'b0; err = 1'b0;
        if (l) begin
            if (sd != 0) m_out = sd;
            else begin m_out = SEED_I; err = 1'b1; end
            m_start = m_out;
            m_steps = 0;
        end else if (e) begin
            n = model_next(m_out, md);
            if (n == m_start) begin w = 1'b1; m_steps = 0; end
            else m_steps = (m_steps + 1) % 16;
            m_out = n;
        end
        push(nm, m_out, m_steps, w, err);
    endtask

    // Step with an expectation taken from a fixed table rather than the model.
    task automatic table_step(string nm, bit md, int o, int s, bit w);
        @(negedge clk);
        rst = 1'b0; en = 1'b1; load = 1'b0; seed_in = '0; mode = md;
        m_out = o; m_steps = s;
        push(nm, o, s, w, 1'b0);
    endtask

    task automatic async_reset(string nm);
        @(negedge clk);
        #2;
        rst = 1'b1;
        m_out = SEED_I; m_start = SEED_I; m_steps = 0;
        push({nm, "_async"}, SEED_I, 0, 1'b0, 1'b0);
        -> async_ev;
        push({nm, "_edge"}, SEED_I, 0, 1'b0, 1'b0);
    endtask

    // Monitor: compare on every rising edge and every asynchronous-reset check.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk or async_ev or done_ev);
            if (done_ev.triggered) begin
                #1;
                if (q.size() != 0) begin
                    total++;
                    bad++;
                    $display("FAIL drain: pending=%0d required=0", q.size());
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            #1;
            if (q.size() != 0) begin
                x = q.pop_front();
                total++;
                if (out !== x.o || steps !== x.s || wrap !== x.w || seed_err !== x.e) begin
                    bad++;
                    $display("FAIL %s: got out=%b steps=%0d wrap=%b seed_err=%b, want out=%b steps=%0d wrap=%b seed_err=%b",
                             x.name, out, steps, wrap, seed_err, x.o, x.s, x.w, x.e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fib_seq[15] = '{3, 7, 15, 14, 13, 10, 5, 11, 6, 12, 9, 2, 4, 8, 1};
        int gal_seq[4]  = '{9, 13, 15, 14};
        int r;

        rst = 1'b1; en = 1'b1; load = 1'b1; seed_in = 4'b0101; mode = 1'b0;
        #1;
        m_out = SEED_I; m_start = SEED_I; m_steps = 0;
        push("reset_async", SEED_I, 0, 1'b0, 1'b0);
        -> async_ev;
        push("reset_edge", SEED_I, 0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) model_cycle($sformatf("hold_%0d", i), 1'b0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 15; i++)
            table_step($sformatf("fib_%0d", i), 1'b0, fib_seq[i], (i == 14) ? 0 : i + 1, i == 14);

        for (int i = 0; i < 4; i++)
            table_step($sformatf("gal_%0d", i), 1'b1, gal_seq[i], i + 1, 1'b0);
        for (int i = 4; i < 14; i++)
            model_cycle($sformatf("gal_%0d", i), 1'b1, 1'b0, 0, 1'b1);
        table_step("gal_wrap", 1'b1, 1, 0, 1'b1);

        model_cycle("load_en", 1'b1, 1'b1, 6, 1'b0);
        for (int i = 0; i < 14; i++)
            model_cycle($sformatf("fib6_%0d", i), 1'b1, 1'b0, 0, 1'b0);
        table_step("fib6_wrap", 1'b0, 6, 0, 1'b1);

        model_cycle("load_zero", 1'b0, 1'b1, 0, 1'b0);
        model_cycle("after_zero", 1'b0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 7; i++)
            model_cycle($sformatf("pre_rst_%0d", i), 1'b1, 1'b0, 0, 1'b0);
        async_reset("mid_rst");
        table_step("post_rst", 1'b0, 3, 1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) async_reset($sformatf("rnd_rst_%0d", i));
            else model_cycle($sformatf("rnd_%0d", i),
                             $urandom_range(0, 3) != 0,
                             $urandom_range(0, 7) == 0,
                             int'($urandom_range(0, 15)),
                             1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        en = 1'b0; load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        -> done_ev;
    end

endmodule
